// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths, types and scheduler state encoding for the
//               9-coefficient, 13-bit FIR control front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DATA_WIDTH = 13;
    localparam int TAPS       = 8;
    localparam int NCOEF      = TAPS + 1;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // Element 0 is H0.
    typedef sample_t [0:NCOEF-1] coef_arr_t;

    typedef enum logic [1:0] {
        CFG   = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Synchronous sample FIFO, power-of-two depth, head word shown
//               combinationally on o_data. Pushes while full and pops while
//               empty are dropped.
// Ports       : i_clk, i_rst_n (async active-low, resets to empty),
//               i_push/i_data, i_pop/o_data, o_full, o_empty, o_count
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   c_CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == c_CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Push is refused while full even if a pop happens in the same cycle.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_sched.sv
`default_nettype none
// ============================================================================
// Module      : fir_sched
// Description : Scheduler front-end for the 9-tap FIR. Collects a coefficient
//               set into shadow registers and commits it atomically, buffers
//               samples and releases them to VIN/DIN only while a committed
//               set is live, and on request drains the buffer and pushes
//               TAPS zero samples through the delay line before reloading.
// Ports       : CLK, RST_n (async active-low)
//               cfg_valid/cfg_data/cfg_ready  - coefficient load, H0 first
//               in_valid/in_data/in_ready     - sample input
//               flush_req                     - flush + reconfigure request
//               fir_vin/fir_din/fir_h         - filter datapath drive
//               coef_ok, busy                 - status
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sched
    import fir_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  flush_req,
    output logic                  fir_vin,
    output logic [DATA_WIDTH-1:0] fir_din,
    output coef_arr_t             fir_h,
    output logic                  coef_ok,
    output logic                  busy
);

    localparam int IW = $clog2(NCOEF);
    localparam int FW = $clog2(TAPS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IW-1:0] c_IDX_ONE   = IW'(1);
    localparam logic [IW-1:0] c_IDX_LAST  = IW'(NCOEF - 1);
    localparam logic [FW-1:0] c_FLSH_ONE  = FW'(1);
    localparam logic [FW-1:0] c_FLSH_LAST = FW'(TAPS - 1);

    sched_state_t    r_state;
    coef_arr_t       r_shadow;
    coef_arr_t       r_h;
    logic [IW-1:0]   r_idx;
    logic [FW-1:0]   r_flush_cnt;
    logic            r_vin;
    sample_t         r_din;
    logic            r_coef_ok;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_cfg_hs;

    assign cfg_ready = (r_state == CFG);
    assign busy      = (r_state == FLUSH);
    assign in_ready  = (r_state != FLUSH) && !w_fifo_full;

    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_state != CFG) && !w_fifo_empty;
    assign w_cfg_hs = cfg_valid & cfg_ready;

    assign fir_vin = r_vin;
    assign fir_din = r_din;
    assign fir_h   = r_h;
    assign coef_ok = r_coef_ok;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST_n),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= CFG;
            r_shadow    <= '0;
            r_h         <= '0;
            r_idx       <= '0;
            r_flush_cnt <= '0;
            r_vin       <= 1'b0;
            r_din       <= '0;
            r_coef_ok   <= 1'b0;
        end else begin
            case (r_state)
                CFG: begin
                    r_vin <= 1'b0;
                    if (w_cfg_hs) begin
                        r_shadow[r_idx] <= cfg_data;
                        if (r_idx == c_IDX_LAST) begin
                            // Whole set lands at once; the last word bypasses
                            // the shadow so no partial set is ever visible.
                            for (int i = 0; i < NCOEF - 1; i++) begin
                                r_h[i] <= r_shadow[i];
                            end
                            r_h[NCOEF-1] <= cfg_data;
                            r_coef_ok    <= 1'b1;
                            r_idx        <= '0;
                            r_state      <= RUN;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end

                RUN: begin
                    if (w_pop) begin
                        r_vin <= 1'b1;
                        r_din <= w_fifo_head;
                    end else begin
                        r_vin <= 1'b0;
                    end
                    if (flush_req) begin
                        r_state <= FLUSH;
                    end
                end

                FLUSH: begin
                    r_vin <= 1'b1;
                    if (w_fifo_count != '0) begin
                        // Drain buffered samples before the zero train.
                        r_din <= w_fifo_head;
                    end else begin
                        r_din <= '0;
                        if (r_flush_cnt == c_FLSH_LAST) begin
                            r_flush_cnt <= '0;
                            r_coef_ok   <= 1'b0;
                            r_state     <= CFG;
                        end else begin
                            r_flush_cnt <= r_flush_cnt + c_FLSH_ONE;
                        end
                    end
                end

                default: r_state <= CFG;
            endcase
        end
    end

endmodule
`default_nettype wire
